mvm_feeder: RTL and testbench
=============================

Name: mvm_feeder

Overview:
- Upstream stage of the 3x3 matrix-vector multiplier.
- Accepts a frame of matrix elements A (row-major) followed by vector elements x over a valid/ready stream and buffers the whole frame.
- Once the frame is complete it pulses the multiplier's `start` and presents one element per cycle on the multiplier's `data_in`.
- It then holds off the next launch until the multiplier signals `done` and has finished draining its result vector.

Parameters:
- MAT_SCALE, 3, matrix dimension M.
- INPUT_WIDTH, 8, element width, signed.
- FRAME_LEN, MAT_SCALE*MAT_SCALE+MAT_SCALE, elements per frame (derived; do not override).
- ADDR_W, $clog2(FRAME_LEN), buffer address / counter width (derived).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  INPUT_WIDTH  incoming element, signed.
- in_valid  input  1  in_data valid.
- in_ready  output  1  feeder can accept an element.
- mvm_start  output  1  one-cycle launch pulse to the multiplier's start.
- mvm_data  output  INPUT_WIDTH  element stream to the multiplier's data_in.
- mvm_done  input  1  multiplier's done pulse.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low. While reset=0:
  - state=IDLE, fill=0, rd_ptr=0, drain count=0.
  - mvm_start=0, mvm_data=0, busy=0.
  - Buffer contents are don't-care and are discarded.
- Reset mid-frame or mid-stream: the partial frame is abandoned and no start is issued afterwards.
- Transfer rule: an element transfers when in_valid && in_ready at a clock edge. It is written to buf[fill], then fill++.
- in_ready = (fill < FRAME_LEN) && state not in {START, STREAM}. Loading is therefore allowed in IDLE, WAIT and DRAIN, so the next frame overlaps computation of the current one.
- State IDLE:
  - If fill==FRAME_LEN, go to START.
  - This includes the cycle in which the last element transfers: the transfer at edge t makes fill full and state START at t+1.
- State START: mvm_start=1 for exactly this one cycle; rd_ptr=0; go to STREAM.
- State STREAM: lasts FRAME_LEN cycles.
  - Stream cycle k (k=0..FRAME_LEN-1) presents mvm_data=buf[k]. k=0 is the cycle immediately after mvm_start was high, which matches the multiplier's registered wr_en_a.
  - Elements 0..M*M-1 are A; elements M*M..FRAME_LEN-1 are x.
  - On the last stream cycle: fill<=0 (buffer released), rd_ptr<=0, go to WAIT.
- State WAIT: mvm_data=0. When mvm_done=1, go to DRAIN with the drain count cleared.
- State DRAIN: count MAT_SCALE cycles while the multiplier outputs y. On count==MAT_SCALE-1, go to IDLE.
- mvm_data is 0 in every state other than STREAM.
- mvm_done outside WAIT is ignored and must not corrupt state.
- Full buffer: in_ready=0 and in_valid is ignored.
- A frame completed during WAIT or DRAIN launches via IDLE. Minimum gap: IDLE for one cycle, then START.
- Latency: last element accepted at edge t -> mvm_start high during cycle t+1 -> first element at t+2 -> last element at t+1+FRAME_LEN.
- Arithmetic: elements are passed through bit-exact, with no sign extension or modification.
- Counters are unsigned ADDR_W bits and never wrap; fill saturates at FRAME_LEN by the in_ready gating.

Decomposition:
- Shared package mvm_pkg holds:
  - constants MAT_SCALE, INPUT_WIDTH, OUTPUT_WIDTH, FRAME_LEN;
  - typedef elem_t (signed INPUT_WIDTH);
  - enum feeder_state_t {IDLE, START, STREAM, WAIT, DRAIN}.
- One sub-module, feeder_buf: FRAME_LEN x INPUT_WIDTH register file with one synchronous write port and one combinational read port.
- The FSM, counters and handshake logic stay in mvm_feeder.

Test Plan:
- Basic launch: reset, then stream 1..12 with in_valid held high. Required response:
  - in_ready=1 for 12 cycles, then 0.
  - mvm_start high exactly one cycle after the 12th accept.
  - mvm_data = 1,2,...,12 on the next 12 consecutive cycles, then 0.
  - busy=1 from START to end of DRAIN.
- End to end with the multiplier: A=[1 2 3;4 5 6;7 8 9], x=[1,-1,2]. Required response:
  - multiplier y = 5,11,17.
  - feeder returns to IDLE exactly MAT_SCALE cycles after mvm_done.
- Backpressure and overlap:
  - Second frame 20..31 offered during WAIT -> accepted with in_ready=1.
  - No second mvm_start until DRAIN ends; then START one cycle after IDLE, streaming 20..31.
  - Same frame offered during STREAM -> in_ready=0 and nothing is written.
- Gappy input: in_valid toggling 1,0,1,0 -> only valid cycles are counted; the launch occurs after the 12th valid beat, with order preserved.
- Reset mid-stream: drive reset=0 at stream cycle 5. Required response:
  - mvm_start and mvm_data go to 0 immediately (asynchronous), busy=0.
  - After release: in_ready=1, fill=0, no spurious start.
- Spurious mvm_done during STREAM and in IDLE -> no state change; stream completes all 12 elements.

Source files
------------

// File: rtl/mvm_pkg.sv
// mvm_pkg: shared constants, element type and feeder states for the 3x3 matrix-vector multiplier
package mvm_pkg;
    localparam int MAT_SCALE = 3;
    localparam int INPUT_WIDTH = 8;
    localparam int OUTPUT_WIDTH = 2 * INPUT_WIDTH + $clog2(MAT_SCALE);
    localparam int FRAME_LEN = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    typedef logic signed [INPUT_WIDTH-1:0] elem_t;
    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, DRAIN} feeder_state_t;
endpackage

// File: rtl/feeder_buf.sv
// feeder_buf: frame register file, one synchronous write port and one combinational read port
//   clk: clock; we/waddr/wdata: write port; raddr/rdata: read port
module feeder_buf #(
    parameter int DEPTH = mvm_pkg::FRAME_LEN,
    parameter int WIDTH = mvm_pkg::INPUT_WIDTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/mvm_feeder.sv
// mvm_feeder: buffers an A/x frame from a valid/ready stream and streams it into the multiplier
//   clk, reset (async, active-low)
//   in_data/in_valid/in_ready: upstream element stream
//   mvm_start/mvm_data: launch pulse and element stream to the multiplier
//   mvm_done: multiplier done pulse; busy: FSM not idle
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int MAT_SCALE = mvm_pkg::MAT_SCALE,
    parameter int INPUT_WIDTH = mvm_pkg::INPUT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mvm_start,
    output logic [INPUT_WIDTH-1:0] mvm_data,
    input  logic                   mvm_done,
    output logic                   busy
);
    localparam int FRAME_LEN = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    localparam int ADDR_W = $clog2(FRAME_LEN);
    localparam logic [ADDR_W-1:0] FULL = ADDR_W'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] DLAST = ADDR_W'(MAT_SCALE - 1);
    feeder_state_t state;
    logic [ADDR_W-1:0] fill, rd_ptr, drain_cnt;
    logic [INPUT_WIDTH-1:0] rd_data;
    logic xfer, last_beat;
    assign in_ready = fill < FULL && state != START && state != STREAM;
    assign xfer = in_valid && in_ready;
    assign last_beat = state == STREAM && rd_ptr == LAST;
    assign mvm_start = state == START;
    assign mvm_data = state == STREAM ? rd_data : '0;
    assign busy = state != IDLE;
    feeder_buf #(.DEPTH(FRAME_LEN), .WIDTH(INPUT_WIDTH), .AW(ADDR_W)) u_buf (
        .clk  (clk),
        .we   (xfer),
        .waddr(fill),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            fill <= '0;
            rd_ptr <= '0;
            drain_cnt <= '0;
        end else begin
            fill <= last_beat ? '0 : fill + ADDR_W'(xfer);
            case (state)
                // the beat that fills the buffer launches on the very next cycle
                IDLE: if (fill == FULL || (xfer && fill == LAST)) state <= START;
                START: begin
                    rd_ptr <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    rd_ptr <= last_beat ? '0 : rd_ptr + 1'b1;
                    if (last_beat) state <= WAIT;
                end
                WAIT: if (mvm_done) begin
                    drain_cnt <= '0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DLAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_feeder.sv
// tb_mvm_feeder: directed and random checks of mvm_feeder against a queue-based reference model
module tb_mvm_feeder;
    logic clk = 0, reset = 0, in_valid = 0, in_ready, mvm_start, mvm_done = 0, busy;
    logic [7:0] in_data = 0, mvm_data;
    int total = 0, bad = 0;
    int ph = -1;
    logic [7:0] mq[$];
    logic [7:0] cap [12];
    bit auto_done = 1;
    logic [7:0] fr [12];

    mvm_feeder dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mvm_start(mvm_start), .mvm_data(mvm_data), .mvm_done(mvm_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ph: -1 idle, 0 launch cycle, 1..12 stream beats, 13 waiting for done, 14..16 drain
    task automatic step(input bit v, input logic [7:0] d, input bit dn, output bit acc);
        bit er;
        in_valid = v;
        in_data = d;
        mvm_done = dn;
        @(negedge clk);
        er = mq.size() < 12 && !(ph >= 0 && ph <= 12);
        chk("in_ready", 8'(in_ready), 8'(er));
        chk("mvm_start", 8'(mvm_start), 8'(ph == 0));
        chk("busy", 8'(busy), 8'(ph >= 0));
        chk("mvm_data", mvm_data, (ph >= 1 && ph <= 12) ? mq[ph-1] : 8'd0);
        if (ph >= 1 && ph <= 12) cap[ph-1] = mvm_data;
        acc = v && er;
        if (acc) mq.push_back(d);
        if (ph == -1) ph = mq.size() == 12 ? 0 : -1;
        else if (ph < 12) ph++;
        else if (ph == 12) begin
            mq.delete();
            ph = 13;
        end else if (ph == 13) ph = dn ? 14 : 13;
        else ph = ph == 16 ? -1 : ph + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 8'h00, auto_done && ph == 13, a);
    endtask

    task automatic send(input bit gappy);
        bit a;
        for (int i = 0; i < 12; i++) begin
            int tries = 0;
            a = 0;
            while (!a && tries < 200) begin
                step(1, fr[i], auto_done && ph == 13, a);
                tries++;
                if (gappy) begin
                    bit b;
                    step(0, 8'hAA, auto_done && ph == 13, b);
                end
            end
            if (!a) chk("send_timeout", 8'(a), 8'd1);
        end
    endtask

    task automatic load(input int base);
        for (int i = 0; i < 12; i++) fr[i] = 8'(base + i);
    endtask

    initial begin
        bit a;
        int y;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 8'(in_ready), 8'd1);
        chk("rst_start", 8'(mvm_start), 8'd0);
        chk("rst_data", mvm_data, 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        @(posedge clk);
        #1;
        reset = 1;
        load(1);
        send(0);
        idle(20);
        fr = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'hFF, 8'd2};
        send(0);
        idle(20);
        for (int i = 0; i < 3; i++) begin
            y = 0;
            for (int j = 0; j < 3; j++) y += $signed(cap[i*3+j]) * $signed(cap[9+j]);
            chk("y", 8'(y), 8'(5 + 6 * i));
        end
        auto_done = 0;
        load(40);
        send(0);
        while (ph >= 0 && ph <= 12) step(1, 8'd20, 0, a);
        load(20);
        send(0);
        idle(4);
        auto_done = 1;
        idle(40);
        load(100);
        send(1);
        idle(20);
        load(60);
        send(0);
        for (int i = 0; i < 20 && ph != 6; i++) idle(1);
        chk("reach_beat5", 8'(ph), 8'd6);
        reset = 0;
        #1;
        chk("arst_start", 8'(mvm_start), 8'd0);
        chk("arst_data", mvm_data, 8'd0);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_ready", 8'(in_ready), 8'd1);
        mq.delete();
        ph = -1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1;
        idle(16);
        step(0, 8'h00, 1, a);
        step(0, 8'h00, 1, a);
        load(200);
        send(0);
        while (ph >= 0 && ph <= 12) step(0, 8'h00, 1, a);
        idle(20);
        for (int i = 0; i < 800; i++)
            step(1'($urandom), 8'($urandom), ph == 13 ? ($urandom % 4 == 0) : ($urandom % 8 == 0), a);
        idle(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
